// File: rtl/psum_writeback.sv
// Drains the corelet OFIFO into psum SRAM at consecutive addresses, one vector per cycle.
// Optional build macro PSUM_WB_RELU_EN clamps negative lanes to zero before the write stage.
module psum_writeback #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11,
    parameter int cnt_w   = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_w-1:0]      base_addr,
    input  logic [cnt_w-1:0]       vec_count,
    input  logic                   hold,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_out,
    output logic                   ofifo_rd,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic [addr_w-1:0]      sram_addr,
    output logic [col*psum_bw-1:0] sram_d,
    output logic                   busy,
    output logic                   done,
    output logic [cnt_w-1:0]       words_wr
);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

    state_t                 state;
    state_t                 next_state;
    logic [addr_w-1:0]      addr_q;
    logic [cnt_w-1:0]       rem;
    logic [col*psum_bw-1:0] wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (vec_count == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (ofifo_rd && (rem == cnt_w'(1))) begin
                    next_state = FLUSH;
                end
            end
            FLUSH:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ofifo_rd = (state == DRAIN) && ofifo_valid && !hold && (rem != '0);
        busy     = (state == DRAIN) || (state == FLUSH);
        done     = (state == DONE);
    end

`ifdef PSUM_WB_RELU_EN
    // Lane sign bit set means negative; such lanes are written as zero.
    always_comb begin
        wdata = ofifo_out;
        for (int i = 0; i < col; i++) begin
            if (ofifo_out[(i+1)*psum_bw-1]) begin
                wdata[i*psum_bw +: psum_bw] = '0;
            end
        end
    end
`else
    assign wdata = ofifo_out;
`endif

    // A pop loads the write stage directly, so the SRAM pins show it the next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            rem       <= '0;
            words_wr  <= '0;
            sram_cen  <= 1'b1;
            sram_wen  <= 1'b1;
            sram_addr <= '0;
            sram_d    <= '0;
        end else begin
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;
            if ((state == IDLE) && start) begin
                addr_q   <= base_addr;
                rem      <= vec_count;
                words_wr <= '0;
            end
            if (ofifo_rd) begin
                sram_cen  <= 1'b0;
                sram_wen  <= 1'b0;
                sram_addr <= addr_q;
                sram_d    <= wdata;
                addr_q    <= addr_q + addr_w'(1);
                rem       <= rem - cnt_w'(1);
                words_wr  <= words_wr + cnt_w'(1);
            end
        end
    end

endmodule

// File: tb/tb_psum_writeback.sv
// Self-checking bench for psum_writeback: table-driven drains, random drains and corner sequences
// checked against a transaction-level model of the OFIFO-to-SRAM transfer.
module tb_psum_writeback;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int AW  = 11;
    localparam int CW  = 11;
    localparam int DW  = COL * BW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] vec_count = '0;
    logic          hold = 1'b0;
    logic          ofifo_valid = 1'b0;
    logic [DW-1:0] ofifo_out = '0;
    logic          ofifo_rd;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_d;
    logic          busy;
    logic          done;
    logic [CW-1:0] words_wr;

    psum_writeback #(.col(COL), .psum_bw(BW), .addr_w(AW), .cnt_w(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .vec_count(vec_count), .hold(hold), .ofifo_valid(ofifo_valid),
        .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd), .sram_cen(sram_cen),
        .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d),
        .busy(busy), .done(done), .words_wr(words_wr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [DW-1:0] fifo[$];

    // Transaction-level model: remaining pops, next address, writes seen, one pending write.
    bit            m_draining = 1'b0;
    int            m_rem = 0;
    int            m_addr = 0;
    int            m_writes = 0;
    bit            pend_valid = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [DW-1:0] pend_data = '0;
    int            last_pop = -10;
    int            done_cyc = -10;

    int            obs_last = -1;
    int            obs_dones = 0;
    logic [DW-1:0] obs_data = '0;
    bit            use_fixed = 1'b0;
    logic [DW-1:0] fixed_vec = '0;

    typedef struct {
        logic [AW-1:0] base;
        logic [CW-1:0] count;
        logic [15:0]   vpat;
        logic [15:0]   hpat;
        int            exp_words;
        int            exp_last;
    } vec_t;

    vec_t tbl[5];

    function automatic logic [DW-1:0] reluRef(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        int lane;
        r = v;
`ifdef PSUM_WB_RELU_EN
        for (int i = 0; i < COL; i++) begin
            lane = $signed(v[i*BW +: BW]);
            if (lane < 0) r[i*BW +: BW] = '0;
        end
`else
        lane = 0;
`endif
        return r;
    endfunction

    function automatic logic [DW-1:0] randVec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_rd",    DW'(ofifo_rd),  DW'(0));
        checkOutput("rst_cen",   DW'(sram_cen),  DW'(1));
        checkOutput("rst_wen",   DW'(sram_wen),  DW'(1));
        checkOutput("rst_addr",  DW'(sram_addr), DW'(0));
        checkOutput("rst_d",     sram_d,         DW'(0));
        checkOutput("rst_busy",  DW'(busy),      DW'(0));
        checkOutput("rst_done",  DW'(done),      DW'(0));
        checkOutput("rst_words", DW'(words_wr),  DW'(0));
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic applyStimulus(input bit st, input logic [AW-1:0] b, input logic [CW-1:0] n,
                                 input bit vg, input bit hd);
        bit exp_rd;
        bit model_idle;
        start       = st;
        base_addr   = b;
        vec_count   = n;
        hold        = hd;
        ofifo_valid = vg && (fifo.size() > 0);
        ofifo_out   = (fifo.size() > 0) ? fifo[0] : randVec();
        #1;
        if (pend_valid) begin
            checkOutput("wr_cen",  DW'(sram_cen),  DW'(0));
            checkOutput("wr_wen",  DW'(sram_wen),  DW'(0));
            checkOutput("wr_addr", DW'(sram_addr), DW'(pend_addr));
            checkOutput("wr_data", sram_d,         pend_data);
            m_writes++;
        end else begin
            checkOutput("idle_en", DW'({sram_cen, sram_wen}), DW'(2'b11));
        end
        if (!sram_cen) begin
            obs_last = int'(sram_addr);
            obs_data = sram_d;
        end
        checkOutput("words_wr", DW'(words_wr), DW'(m_writes));
        checkOutput("busy", DW'(busy), DW'(m_draining || (cyc == last_pop + 1)));
        checkOutput("done", DW'(done), DW'(cyc == done_cyc));
        if (done) obs_dones++;
        model_idle = !m_draining && (cyc != last_pop + 1) && (cyc != done_cyc);
        exp_rd = m_draining && ofifo_valid && !hold;
        checkOutput("ofifo_rd", DW'(ofifo_rd), DW'(exp_rd));
        pend_valid = 1'b0;
        if (exp_rd) begin
            pend_valid = 1'b1;
            pend_addr  = AW'(m_addr);
            pend_data  = reluRef(ofifo_out);
            m_addr     = (m_addr + 1) % 2048;
            m_rem--;
            if (m_rem == 0) begin
                m_draining = 1'b0;
                last_pop   = cyc;
                done_cyc   = cyc + 2;
            end
        end
        if (ofifo_rd && (fifo.size() > 0)) void'(fifo.pop_front());
        if (st && model_idle) begin
            m_addr   = int'(b);
            m_rem    = int'(n);
            m_writes = 0;
            if (n == '0) done_cyc = cyc + 1;
            else m_draining = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
    endtask

    task automatic finishDrain(input logic [15:0] vp, input logic [15:0] hp);
        for (int k = 0; k < 400; k++) begin
            if (!m_draining && (cyc > done_cyc)) break;
            applyStimulus(1'b0, '0, '0, vp[k%16], hp[k%16]);
        end
        if (m_draining || (cyc <= done_cyc)) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout at cycle %0d: got no completion, expected done", cyc);
        end
    endtask

    task automatic runDrain(input logic [AW-1:0] b, input logic [CW-1:0] n,
                            input logic [15:0] vp, input logic [15:0] hp);
        fifo.delete();
        for (int i = 0; i < int'(n); i++) begin
            fifo.push_back((use_fixed && i == 0) ? fixed_vec : randVec());
        end
        obs_dones = 0;
        obs_last  = -1;
        applyStimulus(1'b1, b, n, 1'b1, 1'b0);
        finishDrain(vp, hp);
    endtask

    initial begin
        logic [AW-1:0] rb;
        logic [CW-1:0] rn;
        logic [DW-1:0] relu_exp;

        tbl[0] = '{base: 11'h010, count: 11'd4,  vpat: 16'hFFFF, hpat: 16'h0000, exp_words: 4,  exp_last: 'h013};
        tbl[1] = '{base: 11'h123, count: 11'd0,  vpat: 16'hFFFF, hpat: 16'h0000, exp_words: 0,  exp_last: -1};
        tbl[2] = '{base: 11'h040, count: 11'd3,  vpat: 16'hFFF5, hpat: 16'h0004, exp_words: 3,  exp_last: 'h042};
        tbl[3] = '{base: 11'h7FE, count: 11'd3,  vpat: 16'hFFFF, hpat: 16'h0000, exp_words: 3,  exp_last: 'h000};
        tbl[4] = '{base: 11'h3A0, count: 11'd10, vpat: 16'hA5A5, hpat: 16'h0810, exp_words: 10, exp_last: 'h3A9};

        repeat (2) @(posedge clk);
        #1;
        checkReset();
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            runDrain(tbl[i].base, tbl[i].count, tbl[i].vpat, tbl[i].hpat);
            checkOutput($sformatf("tbl%0d_words", i), DW'(words_wr), DW'(tbl[i].exp_words));
            checkOutput($sformatf("tbl%0d_last", i),  DW'(obs_last), DW'(tbl[i].exp_last));
            checkOutput($sformatf("tbl%0d_dones", i), DW'(obs_dones), DW'(1));
        end

        for (int r = 0; r < 8; r++) begin
            rb = AW'($urandom_range(0, 2047));
            rn = CW'($urandom_range(0, 12));
            runDrain(rb, rn, 16'($urandom()) | 16'h8001, 16'($urandom() & $urandom()));
            checkOutput($sformatf("rnd%0d_words", r), DW'(words_wr), DW'(rn));
            checkOutput($sformatf("rnd%0d_last", r), DW'(obs_last),
                        DW'((rn == '0) ? -1 : ((int'(rb) + int'(rn) - 1) % 2048)));
            checkOutput($sformatf("rnd%0d_dones", r), DW'(obs_dones), DW'(1));
        end

        // Lane clamping on a known vector with negative, positive and extreme lanes.
        fixed_vec = {16'h0001, 16'h7FFF, 16'hFFFF, 16'h0064, 16'h0000, 16'h8000, 16'h0007, 16'hFFFB};
`ifdef PSUM_WB_RELU_EN
        relu_exp  = {16'h0001, 16'h7FFF, 16'h0000, 16'h0064, 16'h0000, 16'h0000, 16'h0007, 16'h0000};
`else
        relu_exp  = fixed_vec;
`endif
        use_fixed = 1'b1;
        runDrain(11'h200, 11'd1, 16'hFFFF, 16'h0000);
        use_fixed = 1'b0;
        checkOutput("relu_data", obs_data, relu_exp);
        checkOutput("relu_addr", DW'(obs_last), DW'(11'h200));

        // Reset after two of five pops abandons the drain.
        fifo.delete();
        for (int i = 0; i < 5; i++) fifo.push_back(randVec());
        applyStimulus(1'b1, 11'h100, 11'd5, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        checkReset();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        cyc++;
        m_draining = 1'b0;
        m_rem      = 0;
        m_writes   = 0;
        pend_valid = 1'b0;
        last_pop   = -10;
        done_cyc   = -10;
        obs_dones  = 0;
        repeat (4) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("post_rst_dones", DW'(obs_dones), DW'(0));

        // A second start during the drain must not disturb address or count.
        fifo.delete();
        for (int i = 0; i < 4; i++) fifo.push_back(randVec());
        obs_last = -1;
        applyStimulus(1'b1, 11'h300, 11'd4, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 11'h055, 11'd2, 1'b1, 1'b0);
        finishDrain(16'hFFFF, 16'h0000);
        checkOutput("busy_start_words", DW'(words_wr), DW'(4));
        checkOutput("busy_start_last",  DW'(obs_last), DW'(11'h303));
        checkOutput("busy_start_dones", DW'(obs_dones), DW'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
